level_debounce: RTL and testbench

Input conditioner that sits directly upstream of the rising-edge detector. It takes a raw, asynchronous, possibly bouncing level (button, external strobe) and synchronises it into the i_clk domain with a two-flop synchroniser. A 4-state debounce FSM then confirms the level, and the block drives the clean `level` into the edge detector. It also counts rejected glitches for debug visibility.

---
 rtl/level_debounce.sv | 98 +++++++++
 tb/tb_level_debounce.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_debounce.sv
// level_debounce: two-flop synchroniser followed by a 4-state debounce FSM with a saturating glitch counter
// Ports:
//   i_clk      system clock, rising edge
//   rst        asynchronous active-high reset
//   raw_in     raw asynchronous level
//   glitch_clr synchronous clear of glitch_cnt (wins over a same-cycle abort)
//   level      debounced, synchronised level
//   p_STATE    current FSM state (LOW=00, WAIT_HIGH=01, HIGH=11, WAIT_LOW=10)
//   busy       high while a transition is being qualified
//   glitch_cnt saturating count of rejected transitions
module level_debounce #(
    parameter int STABLE   = 4,
    parameter int CNT_W    = 4,
    parameter int GLITCH_W = 8,
    parameter int WIDTH    = 2
) (
    input  logic                i_clk,
    input  logic                rst,
    input  logic                raw_in,
    input  logic                glitch_clr,
    output logic                level,
    output logic [WIDTH-1:0]    p_STATE,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);
    typedef enum logic [1:0] {
        LOW       = 2'b00,
        WAIT_HIGH = 2'b01,
        HIGH      = 2'b11,
        WAIT_LOW  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);

    state_t              state, state_nx;
    logic                sync1, sync2;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                abort;
    logic [GLITCH_W-1:0] glitch_nx;

    always_ff @(posedge i_clk or posedge rst)
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            cnt        <= '0;
            glitch_cnt <= '0;
            state      <= LOW;
        end else begin
            sync1      <= raw_in;
            sync2      <= sync1;
            cnt        <= cnt_nx;
            glitch_cnt <= glitch_nx;
            state      <= state_nx;
        end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        abort    = 1'b0;
        case (state)
            LOW:
                if (sync2) begin
                    state_nx = WAIT_HIGH;
                    cnt_nx   = '0;
                end
            WAIT_HIGH:
                if (!sync2) begin
                    state_nx = LOW;
                    abort    = 1'b1;
                end else if (cnt == LAST)
                    state_nx = HIGH;
                else
                    cnt_nx = cnt + CNT_W'(1);
            HIGH:
                if (!sync2) begin
                    state_nx = WAIT_LOW;
                    cnt_nx   = '0;
                end
            WAIT_LOW:
                if (sync2) begin
                    state_nx = HIGH;
                    abort    = 1'b1;
                end else if (cnt == LAST)
                    state_nx = LOW;
                else
                    cnt_nx = cnt + CNT_W'(1);
            default:
                state_nx = LOW;
        endcase
        glitch_nx = glitch_clr ? '0 :
                    (abort && glitch_cnt != '1) ? glitch_cnt + GLITCH_W'(1) : glitch_cnt;
    end

    // WAIT_LOW still reports the old high level until the low is confirmed
    assign level   = (state == HIGH) || (state == WAIT_LOW);
    assign busy    = (state == WAIT_HIGH) || (state == WAIT_LOW);
    assign p_STATE = state;
endmodule

// File: tb/tb_level_debounce.sv
// tb_level_debounce: scoreboard bench for level_debounce (default and GLITCH_W=2 instances)
module tb_level_debounce;
    logic       i_clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw_in = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       level, busy, level_g, busy_g;
    logic [1:0] p_STATE, p_STATE_g;
    logic [7:0] glitch_cnt;
    logic [1:0] glitch_cnt_g;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic [1:0] st;
        logic       lvl;
        logic       bsy;
        logic [7:0] gl;
    } exp_t;

    exp_t exp_q[$];
    int   press_q[$];

    level_debounce dut (
        .i_clk(i_clk), .rst(rst), .raw_in(raw_in), .glitch_clr(glitch_clr),
        .level(level), .p_STATE(p_STATE), .busy(busy), .glitch_cnt(glitch_cnt)
    );

    level_debounce #(.GLITCH_W(2)) dut_g (
        .i_clk(i_clk), .rst(rst), .raw_in(raw_in), .glitch_clr(glitch_clr),
        .level(level_g), .p_STATE(p_STATE_g), .busy(busy_g), .glitch_cnt(glitch_cnt_g)
    );

    always #5 i_clk = ~i_clk;

    function automatic exp_t mk(input logic [1:0] st, input logic [7:0] gl);
        exp_t e;
        e.st  = st;
        e.lvl = (st == 2'b11) || (st == 2'b10);
        e.bsy = (st == 2'b01) || (st == 2'b10);
        e.gl  = gl;
        return e;
    endfunction

    task automatic drive(input logic r, input logic c, input exp_t e);
        raw_in     = r;
        glitch_clr = c;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        raw_in     = 1'b0;
        glitch_clr = 1'b0;
        exp_q.delete();
        repeat (2) begin @(posedge i_clk); #1; end
        rst = 1'b0;
        repeat (3) begin @(posedge i_clk); #1; end
    endtask

    task automatic test_reset;
        #2;
        checks += 2;
        if ({level, p_STATE, busy, glitch_cnt} !== 12'b0) begin
            errors++;
            $display("FAIL reset_state: level=%b state=%b busy=%b glitch=%0d expected all zero", level, p_STATE, busy, glitch_cnt);
        end
        if ({level_g, p_STATE_g, busy_g, glitch_cnt_g} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state_g: level=%b state=%b busy=%b glitch=%0d expected all zero", level_g, p_STATE_g, busy_g, glitch_cnt_g);
        end
    endtask

    task automatic test_reset_mid_qualify;
        logic [1:0] sa [5];
        logic [1:0] sb [7];
        exp_t e;
        sa = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        sb = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, mk(sa[i], 8'd0));
            e = exp_q.pop_front();
            checks++;
            if (p_STATE !== e.st || level !== e.lvl || busy !== e.bsy) begin
                errors++;
                $display("FAIL mid_reset_pre cyc %0d: state=%b level=%b busy=%b expected state=%b level=%b busy=%b", i, p_STATE, level, busy, e.st, e.lvl, e.bsy);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (p_STATE !== 2'b00 || level !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: state=%b level=%b busy=%b expected state=00 level=0 busy=0", p_STATE, level, busy);
        end
        @(posedge i_clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, mk(sb[i], 8'd0));
            e = exp_q.pop_front();
            checks++;
            if (p_STATE !== e.st || level !== e.lvl || busy !== e.bsy) begin
                errors++;
                $display("FAIL mid_reset_requal cyc %0d: state=%b level=%b busy=%b expected state=%b level=%b busy=%b", i, p_STATE, level, busy, e.st, e.lvl, e.bsy);
            end
        end
    endtask

    task automatic test_rise_latency;
        logic [1:0] s [8];
        exp_t e;
        int   bc;
        s  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
        bc = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, mk(s[i], 8'd0));
            e = exp_q.pop_front();
            bc += int'(busy);
            checks++;
            if (p_STATE !== e.st || level !== e.lvl || busy !== e.bsy) begin
                errors++;
                $display("FAIL rise_latency cyc %0d: state=%b level=%b busy=%b expected state=%b level=%b busy=%b", i, p_STATE, level, busy, e.st, e.lvl, e.bsy);
            end
        end
        checks++;
        if (bc != 4) begin
            errors++;
            $display("FAIL rise_busy_cycles: got %0d expected 4", bc);
        end
    endtask

    task automatic test_bounce;
        logic       r [10];
        logic [1:0] s [10];
        exp_t e;
        r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        s = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(r[i], 1'b0, mk(s[i], 8'd0));
            e = exp_q.pop_front();
            checks++;
            if (p_STATE !== e.st || level !== e.lvl || busy !== e.bsy) begin
                errors++;
                $display("FAIL bounce cyc %0d: state=%b level=%b busy=%b expected state=%b level=%b busy=%b", i, p_STATE, level, busy, e.st, e.lvl, e.bsy);
            end
        end
        checks++;
        if (glitch_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bounce_glitch_cnt: got %0d expected 2", glitch_cnt);
        end
    endtask

    task automatic test_high_dropout;
        logic       r [8];
        logic [1:0] s [8];
        exp_t e;
        r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        s = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
        do_reset();
        raw_in = 1'b1;
        repeat (8) begin @(posedge i_clk); #1; end
        checks++;
        if (p_STATE !== 2'b11) begin
            errors++;
            $display("FAIL high_setup: state=%b expected 11", p_STATE);
        end
        for (int i = 0; i < 8; i++) begin
            drive(r[i], 1'b0, mk(s[i], 8'd0));
            e = exp_q.pop_front();
            checks++;
            if (p_STATE !== e.st || level !== e.lvl || busy !== e.bsy) begin
                errors++;
                $display("FAIL high_dropout cyc %0d: state=%b level=%b busy=%b expected state=%b level=%b busy=%b", i, p_STATE, level, busy, e.st, e.lvl, e.bsy);
            end
        end
        checks++;
        if (glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL high_dropout_glitch: got %0d expected 1", glitch_cnt);
        end
    endtask

    function automatic logic t5_raw(input int j);
        return (j >= 0) && (((j % 3 == 0) && j < 15) || j == 17);
    endfunction

    task automatic test_glitch_saturate;
        exp_t       e;
        logic [7:0] g;
        logic [1:0] st;
        logic       c;
        g = 8'd0;
        do_reset();
        for (int j = 0; j < 22; j++) begin
            c  = (j == 20);
            st = (j >= 2 && t5_raw(j - 2)) ? 2'b01 : 2'b00;
            if (c) g = 8'd0;
            else if (j >= 3 && t5_raw(j - 3)) g = (g == 8'd3) ? 8'd3 : g + 8'd1;
            drive(t5_raw(j), c, mk(st, g));
            e = exp_q.pop_front();
            checks++;
            if (p_STATE_g !== e.st || {6'b0, glitch_cnt_g} !== e.gl) begin
                errors++;
                $display("FAIL glitch_sat cyc %0d: state=%b glitch=%0d expected state=%b glitch=%0d", j, p_STATE_g, glitch_cnt_g, e.st, e.gl);
            end
            if (j == 19 || j == 20) begin
                checks++;
                if (glitch_cnt !== ((j == 19) ? 8'd5 : 8'd0)) begin
                    errors++;
                    $display("FAIL glitch_wide cyc %0d: got %0d expected %0d", j, glitch_cnt, (j == 19) ? 5 : 0);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] seq[$];
        logic       prev;
        int         pulses, pc, id;
        pulses = 0;
        pc     = 0;
        press_q.delete();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 10; i++) seq.push_back({i == 0, 1'b1});
            repeat (3) seq.push_back(2'b00);
            seq.push_back(2'b01);
            repeat (8) seq.push_back(2'b00);
            seq.push_back(2'b01);
            repeat (8) seq.push_back(2'b00);
        end
        do_reset();
        prev = level;
        foreach (seq[k]) begin
            if (seq[k][1]) press_q.push_back(pc++);
            raw_in = seq[k][0];
            @(posedge i_clk);
            #1;
            if (level && !prev) begin
                checks++;
                if (press_q.size() == 0) begin
                    errors++;
                    $display("FAIL chain_extra_pulse cyc %0d: pulse %0d with no pending press", k, pulses);
                end else begin
                    id = press_q.pop_front();
                    if (id != pulses) begin
                        errors++;
                        $display("FAIL chain_pulse_order: got press %0d expected %0d", id, pulses);
                    end
                end
                pulses++;
            end
            prev = level;
        end
        checks += 3;
        if (pulses != 3) begin
            errors++;
            $display("FAIL chain_pulse_count: got %0d expected 3", pulses);
        end
        if (level !== 1'b0 || p_STATE !== 2'b00) begin
            errors++;
            $display("FAIL chain_final: level=%b state=%b expected level=0 state=00", level, p_STATE);
        end
        if (glitch_cnt !== 8'd6) begin
            errors++;
            $display("FAIL chain_glitch: got %0d expected 6", glitch_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_qualify();
        test_rise_latency();
        test_bounce();
        test_high_dropout();
        test_glitch_saturate();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
